ws2812_transmitter: RTL

Serial output engine for the WS2812 LED strip. It reads GRB pixel bytes from the shared pixel RAM, which the CPU register block fills in. It serialises them MSB-first onto the single-wire WS2812 data line using the NRZ pulse-width code. After each frame it holds the line low for the latch/reset gap, then repeats, so the strip is refreshed continuously.

---
 rtl/ws2812_transmitter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ws2812_transmitter.sv
// ws2812_transmitter
//
// Serial output engine for a WS2812 LED strip. It reads GRB bytes from a
// synchronous pixel RAM and sends them MSB first on a single wire using the
// WS2812 NRZ pulse-width code. After every frame it holds the line low for
// the latch gap and then starts again, so the strip is refreshed continuously.
//
// Ports
//   clk               clock
//   reset_n           asynchronous active-low reset
//   number_of_pixels  pixels in the strip (sampled at the end of each latch gap)
//   pixel_addr        read address into the GRB byte RAM
//   pixel_dbi         RAM read data, valid one cycle after pixel_addr
//   ws2812_data       registered serial line to the strip
//   busy              high while a frame is being primed or sent
//
// state | meaning
// LATCH | line low for RESET_CYCLES, then sample the pixel count
// PRIME | two cycles waiting for byte 0 to come back from the RAM
// SEND  | shifting bits out, BIT_CYCLES per bit, no gaps

module ws2812_transmitter #(
  parameter int MAX_PIXELS   = 4,
  parameter int T0H_CYCLES   = 11,
  parameter int T1H_CYCLES   = 22,
  parameter int BIT_CYCLES   = 34,
  parameter int RESET_CYCLES = 8100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] number_of_pixels,
  output logic [9:0] pixel_addr,
  input  logic [7:0] pixel_dbi,
  output logic       ws2812_data,
  output logic       busy
);

  // One counter serves the latch gap, the prime delay and the bit period.
  localparam int CNT_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] T0H_CNT    = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H_CNT    = CNT_W'(T1H_CYCLES);
  localparam logic [7:0]       MAX_PIX    = 8'(MAX_PIXELS);

  typedef enum logic [1:0] {
    LATCH = 2'd0,
    PRIME = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [9:0]       addr_next;
  logic [9:0]       byte_idx, byte_next;
  logic [9:0]       total_bytes, total_next;
  logic [7:0]       shift, shift_next;
  logic [2:0]       bit_cnt, bit_next;
  logic             line_next;
  logic [7:0]       n_clamp;

  assign n_clamp = (number_of_pixels > MAX_PIX) ? MAX_PIX : number_of_pixels;
  assign busy    = (state != LATCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LATCH;
      cnt         <= '0;
      pixel_addr  <= '0;
      byte_idx    <= '0;
      total_bytes <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      ws2812_data <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pixel_addr  <= addr_next;
      byte_idx    <= byte_next;
      total_bytes <= total_next;
      shift       <= shift_next;
      bit_cnt     <= bit_next;
      ws2812_data <= line_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = pixel_addr;
    byte_next  = byte_idx;
    total_next = total_bytes;
    shift_next = shift;
    bit_next   = bit_cnt;
    line_next  = 1'b0;

    case (state)
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          cnt_next   = '0;
          total_next = 10'(n_clamp) * 10'd3;
          if (n_clamp != 8'd0) begin
            addr_next  = '0;
            byte_next  = '0;
            state_next = PRIME;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      PRIME: begin
        if (cnt == PRIME_LAST) begin
          shift_next = pixel_dbi;
          addr_next  = 10'd1;
          bit_next   = 3'd7;
          cnt_next   = '0;
          state_next = SEND;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      SEND: begin
        line_next = (cnt < (shift[7] ? T1H_CNT : T0H_CNT));
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (bit_cnt != 3'd0) begin
            shift_next = {shift[6:0], 1'b0};
            bit_next   = bit_cnt - 3'd1;
          end else if (byte_idx == total_bytes - 10'd1) begin
            state_next = LATCH;
          end else begin
            // The RAM has been showing byte_idx+1 for the whole byte just
            // sent; point it at the one after that for the next load.
            shift_next = pixel_dbi;
            byte_next  = byte_idx + 10'd1;
            addr_next  = byte_idx + 10'd2;
            bit_next   = 3'd7;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        state_next = LATCH;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
